// File: rtl/l2_cache_assoc.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : l2_cache_assoc
// Purpose  : N-way set-associative write-back L2 cache with tree pseudo-LRU
//            replacement and an integrated hit/writeback/allocate controller.
//            Whole-line transfers on both the arbiter and memory sides.
// Revision : 1.0 - initial release
// ============================================================================
module l2_cache_assoc #(
  parameter int WAYS   = 8,
  parameter int SETS   = 8,
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [LINE_W-1:0] l2_wdata,
  output logic [LINE_W-1:0] l2_rdata,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  state_t state;

  // Tag/data storage is deliberately left unreset; valid bits qualify it.
  logic [TAG_W-1:0]  tag_arr  [WAYS][SETS];
  logic [LINE_W-1:0] data_arr [WAYS][SETS];

  logic [SETS-1:0][WAYS-1:0] valid;
  logic [SETS-1:0][WAYS-1:0] dirty;
  logic [SETS-1:0][WAYS-2:0] plru;    // heap-ordered tree, node n at bit n-1

  logic [WAY_W-1:0] victim;           // way chosen at miss time
  logic [TAG_W-1:0] req_tag;          // miss address, held across the refill
  logic [IDX_W-1:0] req_idx;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             unused_off;
  logic             req;

  assign idx        = mem_address[OFF_W +: IDX_W];
  assign tag        = mem_address[ADDR_W-1 -: TAG_W];
  assign unused_off = ^mem_address[OFF_W-1:0];
  assign req        = mem_read | mem_write;

  logic [WAYS-1:0] hit;

  for (genvar w = 0; w < WAYS; w++) begin : g_hit
    assign hit[w] = valid[idx][w] && (tag_arr[w][idx] == tag);
  end

  logic             any_hit;
  logic [WAY_W-1:0] hit_way;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;

  // Encode the hitting way and find the lowest-index invalid way of the set.
  always_comb begin
    any_hit   = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit[w]) begin
        any_hit = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid[idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  logic [WAY_W-1:0] plru_way;
  logic [WAYS-2:0]  plru_upd;
  logic [WAY_W-1:0] vic_sel;

  // Walk the PLRU tree for the replacement way, and build the updated tree
  // that points every node on the hit way's path away from it.
  always_comb begin : plru_logic
    logic [WAY_W:0]   node;
    logic [WAY_W-1:0] ni;
    logic             dir;
    node = (WAY_W + 1)'(1);
    for (int l = 0; l < WAY_W; l++) begin
      ni   = node[WAY_W-1:0] - WAY_W'(1);
      node = {node[WAY_W-1:0], plru[idx][ni]};
    end
    plru_way = node[WAY_W-1:0];

    plru_upd = plru[idx];
    node     = {1'b1, hit_way};
    for (int l = 0; l < WAY_W; l++) begin
      dir          = node[0];
      node         = node >> 1;
      ni           = node[WAY_W-1:0] - WAY_W'(1);
      plru_upd[ni] = ~dir;
    end

    vic_sel = inv_found ? inv_way : plru_way;
  end

  logic fill_we;
  logic hit_we;

  assign fill_we = (state == ALLOCATE) && pmem_resp && pmem_read;
  assign hit_we  = (state == COMPARE) && mem_write && any_hit;

  // Line storage: refill from memory or a write hit from the arbiter.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_arr[victim][req_idx] <= pmem_rdata;
      tag_arr[victim][req_idx]  <= req_tag;
    end else if (hit_we) begin
      data_arr[hit_way][idx] <= l2_wdata;
    end
  end

  // Controller: state, registered outputs and per-line status bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      l2_rdata     <= '0;
      mem_resp     <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      valid        <= '0;
      dirty        <= '0;
      plru         <= '0;
      victim       <= '0;
      req_tag      <= '0;
      req_idx      <= '0;
    end else begin
      mem_resp <= 1'b0;
      case (state)
        IDLE: begin
          // The cycle carrying mem_resp still sees the old request held.
          if (req && !mem_resp) state <= COMPARE;
        end
        COMPARE: begin
          if (!req) begin
            state <= IDLE;
          end else if (any_hit) begin
            mem_resp   <= 1'b1;
            plru[idx]  <= plru_upd;
            if (mem_write) dirty[idx][hit_way] <= 1'b1;
            else           l2_rdata <= data_arr[hit_way][idx];
            state      <= IDLE;
          end else begin
            victim  <= vic_sel;
            req_tag <= tag;
            req_idx <= idx;
            if (valid[idx][vic_sel] && dirty[idx][vic_sel]) begin
              pmem_write   <= 1'b1;
              pmem_address <= {tag_arr[vic_sel][idx], idx, {OFF_W{1'b0}}};
              pmem_wdata   <= data_arr[vic_sel][idx];
              state        <= WRITEBACK;
            end else begin
              pmem_read    <= 1'b1;
              pmem_address <= {tag, idx, {OFF_W{1'b0}}};
              state        <= ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp && pmem_write) begin
            pmem_write   <= 1'b0;
            pmem_read    <= 1'b1;
            pmem_address <= {req_tag, req_idx, {OFF_W{1'b0}}};
            state        <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (pmem_resp && pmem_read) begin
            pmem_read               <= 1'b0;
            valid[req_idx][victim]  <= 1'b1;
            dirty[req_idx][victim]  <= 1'b0;
            state                   <= COMPARE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l2_cache_assoc.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_l2_cache_assoc
// Purpose  : Directed self-checking bench for l2_cache_assoc (4-way, 8 sets)
//            with a fixed-latency physical memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_cache_assoc;
  localparam int WAYS   = 4;
  localparam int SETS   = 8;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;
  localparam int LAT    = 3;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              mem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  always #5 clk = ~clk;

  l2_cache_assoc #(.WAYS(WAYS), .SETS(SETS), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  int checks = 0;
  int errors = 0;
  int n_rd = 0;
  int n_wr = 0;
  int both_cnt = 0;
  logic [ADDR_W-1:0] last_rd_addr = '0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  logic [LINE_W-1:0] last_wr_data = '0;

  function automatic logic [LINE_W-1:0] mem_line(input logic [ADDR_W-1:0] a);
    return {8{a ^ 16'h5A5A}};
  endfunction

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Physical memory: answers any held strobe after LAT cycles.
  initial begin : pmem_model
    int cnt;
    cnt = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (pmem_read && pmem_write) both_cnt++;
      if (pmem_read || pmem_write) begin
        cnt++;
        if (cnt == LAT) begin
          cnt = 0;
          pmem_resp = 1'b1;
          if (pmem_write) begin
            n_wr++;
            last_wr_addr = pmem_address;
            last_wr_data = pmem_wdata;
          end else begin
            n_rd++;
            last_rd_addr = pmem_address;
            pmem_rdata   = mem_line(pmem_address);
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // One arbiter transaction; cyc counts cycles from request to mem_resp.
  task automatic do_req(input logic wr, input logic rd, input logic [ADDR_W-1:0] addr,
                        input logic [LINE_W-1:0] wd, output logic [LINE_W-1:0] line,
                        output int cyc);
    logic got;
    @(negedge clk);
    mem_write   = wr;
    mem_read    = rd;
    mem_address = addr;
    l2_wdata    = wd;
    cyc  = 0;
    got  = 1'b0;
    line = '0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (mem_resp) begin
        got  = 1'b1;
        line = l2_rdata;
      end
    end
    if (!got) check("resp_timeout", 1, 0);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check("resp_pulse", mem_resp, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    logic [LINE_W-1:0] line, lb, le;
    logic [ADDR_W-1:0] a;
    int cyc, rd0, wr0;
    mem_read = 0; mem_write = 0; mem_address = '0; l2_wdata = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mem_resp", mem_resp, 0);
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_pmem_addr", pmem_address, 0);
    check("rst_l2_rdata", l2_rdata, 0);
    rst_n = 1'b1;

    // 1: cold read miss
    do_req(0, 1, 16'h1230, '0, line, cyc);
    check("t1_data", line, mem_line(16'h1230));
    check("t1_lat", cyc, 6);
    check("t1_nrd", n_rd, 1);
    check("t1_nwr", n_wr, 0);
    check("t1_rd_addr", last_rd_addr, 16'h1230);

    // 2: repeat read hits
    do_req(0, 1, 16'h1230, '0, line, cyc);
    check("t2_data", line, mem_line(16'h1230));
    check("t2_lat", cyc, 2);
    check("t2_nrd", n_rd, 1);

    // 3: dirty line evicted after filling the set
    lb = {4{32'hB0B0_0001}};
    do_req(1, 0, 16'h1230, lb, line, cyc);
    check("t3_wr_lat", cyc, 2);
    do_req(0, 1, 16'h1230, '0, line, cyc);
    check("t3_rd_b", line, lb);
    for (int t = 1; t <= 3; t++) begin
      a = 16'(t << 7) | 16'h0030;
      do_req(0, 1, a, '0, line, cyc);
      check("t3_fill_lat", cyc, 6);
    end
    check("t3_nwr0", n_wr, 0);
    do_req(0, 1, 16'h0230, '0, line, cyc);
    check("t3_evict_lat", cyc, 9);
    check("t3_nwr", n_wr, 1);
    check("t3_wb_addr", last_wr_addr, 16'h1230);
    check("t3_wb_data", last_wr_data, lb);
    check("t3_rd_addr", last_rd_addr, 16'h0230);
    check("t3_data", line, mem_line(16'h0230));

    // 4: PLRU victim after touching ways 0..3 then way 0
    for (int t = 1; t <= 4; t++) begin
      do_req(1, 0, 16'(t << 7), {8{16'hD000 | 16'(t)}}, line, cyc);
      check("t4_wmiss_lat", cyc, 6);
    end
    do_req(0, 1, 16'h0080, '0, line, cyc);
    check("t4_rd_d1", line, {8{16'hD001}});
    check("t4_rd_lat", cyc, 2);
    wr0 = n_wr;
    do_req(0, 1, 16'h0280, '0, line, cyc);
    check("t4_nwr", n_wr, wr0 + 1);
    check("t4_victim_addr", last_wr_addr, 16'h0180);
    check("t4_victim_data", last_wr_data, {8{16'hD003}});

    // 5: reset during ALLOCATE
    @(negedge clk);
    mem_read = 1'b1;
    mem_address = 16'h0050;
    for (int i = 0; i < 20 && !pmem_read; i++) @(negedge clk);
    check("t5_alloc_seen", pmem_read, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_pmem_read_drop", pmem_read, 0);
    check("t5_pmem_write_low", pmem_write, 0);
    mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd0 = n_rd;
    do_req(0, 1, 16'h0050, '0, line, cyc);
    check("t5_remiss_lat", cyc, 6);
    check("t5_nrd", n_rd, rd0 + 1);
    check("t5_data", line, mem_line(16'h0050));
    do_req(0, 1, 16'h1230, '0, line, cyc);
    check("t5_cleared_lat", cyc, 6);

    // 6: read and write together on a hit behaves as a write
    le = {4{32'hE6E6_0606}};
    do_req(1, 1, 16'h0050, le, line, cyc);
    check("t6_rw_lat", cyc, 2);
    do_req(0, 1, 16'h0050, '0, line, cyc);
    check("t6_rd_e", line, le);
    for (int t = 1; t <= 3; t++) begin
      a = 16'(t << 7) | 16'h0050;
      do_req(0, 1, a, '0, line, cyc);
    end
    wr0 = n_wr;
    do_req(0, 1, 16'h0250, '0, line, cyc);
    check("t6_nwr", n_wr, wr0 + 1);
    check("t6_wb_addr", last_wr_addr, 16'h0050);
    check("t6_wb_data", last_wr_data, le);

    check("pmem_both_high", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
